bit_serializer: RTL

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: a small word FIFO feeds a shift register that
// advances one bit each time the phase clock toggles `next`.
module bit_serializer #(
    parameter int BYTE_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int LSB_FIRST  = 1,
    parameter int IDLE_BIT   = 0
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [BYTE_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          next,
    output logic                          data,
    output logic                          busy,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int   AW      = $clog2(FIFO_DEPTH);
    localparam int   CW      = AW + 1;
    localparam int   IW      = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
    localparam logic LP_IDLE = (IDLE_BIT != 0);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    logic [BYTE_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wptr, r_rptr;
    logic [CW-1:0]         r_count;
    logic                  r_next_q;
    state_t                r_state;
    logic [BYTE_WIDTH-1:0] r_shift;
    logic [IW-1:0]         r_idx;
    logic                  r_data, r_busy, r_underrun;

    logic                  w_req, w_push, w_pop, w_empty, w_last;
    logic [BYTE_WIDTH-1:0] w_head, w_shift_nxt;
    logic                  w_head_first, w_shift_bit;

    assign w_req   = next ^ r_next_q;
    assign w_empty = (r_count == '0);
    assign w_last  = (r_idx == IW'(BYTE_WIDTH - 1));
    // in_ready looks only at the registered count, so a same-cycle pop never
    // opens a slot in a full FIFO.
    assign in_ready = (r_count < CW'(FIFO_DEPTH));
    assign w_push   = in_valid & in_ready;
    assign w_pop    = w_req & ~w_empty & ((r_state == S_IDLE) | w_last);
    assign w_head   = r_mem[r_rptr];

    assign w_head_first = (LSB_FIRST != 0) ? w_head[0] : w_head[BYTE_WIDTH-1];
    assign w_shift_nxt  = (LSB_FIRST != 0) ? (r_shift >> 1) : (r_shift << 1);
    assign w_shift_bit  = (LSB_FIRST != 0) ? w_shift_nxt[0] : w_shift_nxt[BYTE_WIDTH-1];

    always_ff @(posedge clock) begin
        if (reset_n && w_push) r_mem[r_wptr] <= in_data;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // next_q tracks next even in reset so leaving reset never fakes a request.
    always_ff @(posedge clock) r_next_q <= next;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_idx      <= '0;
            r_data     <= LP_IDLE;
            r_busy     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req && !w_empty) begin
                        r_shift <= w_head;
                        r_idx   <= '0;
                        r_data  <= w_head_first;
                        r_busy  <= 1'b1;
                        r_state <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (w_req) begin
                        if (!w_last) begin
                            r_shift <= w_shift_nxt;
                            r_idx   <= r_idx + 1'b1;
                            r_data  <= w_shift_bit;
                        end else if (!w_empty) begin
                            r_shift <= w_head;
                            r_idx   <= '0;
                            r_data  <= w_head_first;
                        end else begin
                            r_idx      <= '0;
                            r_data     <= LP_IDLE;
                            r_busy     <= 1'b0;
                            r_underrun <= 1'b1;
                            r_state    <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data       = r_data;
    assign busy       = r_busy;
    assign underrun   = r_underrun;
    assign fifo_count = r_count;
endmodule
